// File: rtl/fio_loader_if.sv
// Host-side streams of the FileIO loader.
//   in_valid/in_ready/in_data    : 32-bit command+data words from the host
//   out_valid/out_ready/out_data : 32-bit response words to the host
// master = host side, slave = loader side.
interface fio_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fio_loader.sv
// FileIO sequencer for gpu_top_checking. Decodes a 32-bit host word stream
// (header op[31:28] base[25:16] cnt[9:0], N = cnt+1) into TM / ICache / MEM /
// latency-table writes, runs the GPU and reports its cycle count, and dumps
// MEM lines back as 32-bit words, MSB word first.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   bus                  : host in/out streams (fio_loader_if.slave)
//   busy, cmd_err        : not idle; sticky unknown-opcode flag
//   *_FIO_TM / *_TM_FIO  : task-manager write, start, clear, finished
//   FileIO_*_ICache      : instruction-cache write port
//   FIO_MEMWRITE/ADDR/WRITE_DATA/READ_DATA : data-memory port
//   FIO_CACHE_*          : cache-latency table write port
module fio_loader #(
    parameter int unsigned mem_depth      = 256,
    parameter int unsigned shmem_depth    = 256,
    parameter int unsigned addr_width     = $clog2(mem_depth + shmem_depth),
    parameter int unsigned mem_addr_width = $clog2(mem_depth),
    parameter int unsigned MEM_RD_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    fio_loader_if.slave               bus,
    output logic                      busy,
    output logic                      cmd_err,
    output logic                      Write_Enable_FIO_TM,
    output logic [28:0]               Write_Data_FIO_TM,
    output logic                      start_FIO_TM,
    output logic                      clear_FIO_TM,
    input  logic                      finished_TM_FIO,
    output logic                      FileIO_Wen_ICache,
    output logic [9:0]                FileIO_Addr_ICache,
    output logic [31:0]               FileIO_Din_ICache,
    input  logic [31:0]               FileIO_Dout_ICache,
    output logic                      FIO_MEMWRITE,
    output logic [addr_width-1:0]     FIO_ADDR,
    output logic [255:0]              FIO_WRITE_DATA,
    input  logic [255:0]              FIO_READ_DATA,
    output logic                      FIO_CACHE_LAT_WRITE,
    output logic [4:0]                FIO_CACHE_LAT_VALUE,
    output logic [mem_addr_width-1:0] FIO_CACHE_MEM_ADDR
);
    localparam int unsigned LatW = $clog2(MEM_RD_LAT + 1) + 1;

    typedef enum logic [3:0] {
        StIdle, StTmWr, StIcWr, StMemCol, StMemWr, StEmuWr,
        StRun, StDumpRd, StDumpWait, StDumpOut
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      base_q, cnt_q, k_q;
    logic [2:0]      word_q;
    logic [LatW-1:0] lat_q;
    logic [223:0]    col_q;
    logic [255:0]    dump_q;
    logic [31:0]     run_cnt_q, res_q;
    logic            done_q;

    logic        acc, out_fire, last;
    logic [3:0]  op;
    logic [31:0] addr_k, addr_n, hdr_base;
    logic        unused;

    assign op       = bus.in_data[31:28];
    assign acc      = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;
    assign last     = (k_q == cnt_q);
    // Wide sums; each port takes its own low bits, which gives the address wrap.
    assign addr_k   = 32'(base_q) + 32'(k_q);
    assign addr_n   = addr_k + 32'd1;
    assign hdr_base = 32'(bus.in_data[25:16]);
    assign unused   = ^{FileIO_Dout_ICache, addr_k, addr_n, hdr_base};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    case (op)
                        4'd0:    state_d = StTmWr;
                        4'd1:    state_d = StIcWr;
                        4'd2:    state_d = StMemCol;
                        4'd3:    state_d = StEmuWr;
                        4'd4:    state_d = StRun;
                        4'd5:    state_d = StDumpRd;
                        default: state_d = StIdle;
                    endcase
                end
            end
            StTmWr, StIcWr, StEmuWr: if (acc && last) state_d = StIdle;
            StMemCol:   if (acc && word_q == 3'd7) state_d = StMemWr;
            StMemWr:    state_d = last ? StIdle : StMemCol;
            StRun:      if (done_q && bus.out_ready) state_d = StIdle;
            StDumpRd:   state_d = (MEM_RD_LAT == 0) ? StDumpOut : StDumpWait;
            StDumpWait: if (lat_q == LatW'(MEM_RD_LAT)) state_d = StDumpOut;
            StDumpOut:  if (out_fire && word_q == 3'd7) state_d = last ? StIdle : StDumpRd;
            default:    state_d = StIdle;
        endcase
    end

    // Stream outputs
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = res_q;
        busy          = (state_q != StIdle);
        unique case (state_q)
            StIdle, StTmWr, StIcWr, StEmuWr, StMemCol: bus.in_ready = !rst;
            StRun: bus.out_valid = done_q;
            StDumpOut: begin
                bus.out_valid = 1'b1;
                bus.out_data  = dump_q[255:224];
            end
            default: ;
        endcase
    end

    // Datapath, registered strobes and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0; cnt_q <= '0; k_q <= '0; word_q <= '0; lat_q <= '0;
            col_q <= '0; dump_q <= '0; run_cnt_q <= '0; res_q <= '0; done_q <= 1'b0;
            cmd_err <= 1'b0;
            Write_Enable_FIO_TM <= 1'b0; Write_Data_FIO_TM <= '0;
            start_FIO_TM <= 1'b0; clear_FIO_TM <= 1'b0;
            FileIO_Wen_ICache <= 1'b0; FileIO_Addr_ICache <= '0; FileIO_Din_ICache <= '0;
            FIO_MEMWRITE <= 1'b0; FIO_ADDR <= '0; FIO_WRITE_DATA <= '0;
            FIO_CACHE_LAT_WRITE <= 1'b0; FIO_CACHE_LAT_VALUE <= '0; FIO_CACHE_MEM_ADDR <= '0;
        end else begin
            Write_Enable_FIO_TM <= 1'b0;
            FileIO_Wen_ICache   <= 1'b0;
            FIO_MEMWRITE        <= 1'b0;
            FIO_CACHE_LAT_WRITE <= 1'b0;
            clear_FIO_TM        <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (acc) begin
                        base_q <= bus.in_data[25:16];
                        cnt_q  <= bus.in_data[9:0];
                        k_q    <= '0;
                        word_q <= '0;
                        case (op)
                            4'd0, 4'd1, 4'd2, 4'd3: ;
                            4'd4: begin
                                start_FIO_TM <= 1'b1;
                                run_cnt_q    <= '0;
                                done_q       <= 1'b0;
                            end
                            4'd5:    FIO_ADDR <= hdr_base[addr_width-1:0];
                            4'd6:    clear_FIO_TM <= 1'b1;
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end
                StTmWr: if (acc) begin
                    Write_Enable_FIO_TM <= 1'b1;
                    Write_Data_FIO_TM   <= bus.in_data[28:0];
                    k_q                 <= k_q + 10'd1;
                end
                StIcWr: if (acc) begin
                    FileIO_Wen_ICache  <= 1'b1;
                    FileIO_Addr_ICache <= addr_k[9:0];
                    FileIO_Din_ICache  <= bus.in_data;
                    k_q                <= k_q + 10'd1;
                end
                StEmuWr: if (acc) begin
                    FIO_CACHE_LAT_WRITE <= 1'b1;
                    FIO_CACHE_LAT_VALUE <= bus.in_data[4:0];
                    FIO_CACHE_MEM_ADDR  <= addr_k[mem_addr_width-1:0];
                    k_q                 <= k_q + 10'd1;
                end
                StMemCol: if (acc) begin
                    // First word ends up in the top slot after eight shifts.
                    col_q  <= {col_q[191:0], bus.in_data};
                    word_q <= word_q + 3'd1;
                    if (word_q == 3'd7) begin
                        FIO_MEMWRITE   <= 1'b1;
                        FIO_WRITE_DATA <= {col_q, bus.in_data};
                        FIO_ADDR       <= addr_k[addr_width-1:0];
                    end
                end
                StMemWr: k_q <= k_q + 10'd1;
                StRun: begin
                    if (!done_q) begin
                        if (finished_TM_FIO) begin
                            start_FIO_TM <= 1'b0;
                            done_q       <= 1'b1;
                            res_q        <= run_cnt_q;
                        end else begin
                            run_cnt_q <= run_cnt_q + 32'd1;
                        end
                    end
                end
                StDumpRd: begin
                    if (MEM_RD_LAT == 0) dump_q <= FIO_READ_DATA;
                    else                 lat_q  <= LatW'(1);
                end
                StDumpWait: begin
                    if (lat_q == LatW'(MEM_RD_LAT)) dump_q <= FIO_READ_DATA;
                    else                            lat_q  <= lat_q + LatW'(1);
                end
                StDumpOut: if (out_fire) begin
                    dump_q <= {dump_q[223:0], 32'h0};
                    word_q <= word_q + 3'd1;
                    if (word_q == 3'd7) begin
                        k_q <= k_q + 10'd1;
                        // Next line address goes out only once the last word has left.
                        if (!last) FIO_ADDR <= addr_n[addr_width-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fio_loader.md
# fio_loader

Hardware FileIO sequencer sitting directly upstream of `gpu_top_checking`: it drives every FileIO port of the GPU top. It accepts a 32-bit command/data word stream from the host and performs these operations:
- loads the task manager (TM), ICache, data memory (MEM) and cache-latency table (EMU);
- starts execution and waits for completion;
- streams MEM contents back as 32-bit words.

It replaces bench-only initialization and dump sequencing so the GPU can be run on silicon/FPGA.

## Interface
- `mem_depth`, 256, MEM lines (non-shared).
- `shmem_depth`, 256, shared-memory lines.
- `addr_width`, $clog2(mem_depth+shmem_depth), FIO_ADDR width.
- `mem_addr_width`, $clog2(mem_depth), FIO_CACHE_MEM_ADDR width.
- `MEM_RD_LAT`, 1, cycles from FIO_ADDR change to valid FIO_READ_DATA.
- `clk  in  1  clock`
- `rst  in  1  reset, asynchronous, active-high`
- `in_valid / in_ready / in_data  in/out/in  1/1/32  host command+data stream`
- `out_valid / out_ready / out_data  out/in/out  1/1/32  response stream`
- `busy  out  1  not in IDLE`
- `cmd_err  out  1  sticky: unknown opcode seen`
- `Write_Enable_FIO_TM  out  1`, `Write_Data_FIO_TM  out  29`, `start_FIO_TM  out  1`, `clear_FIO_TM  out  1`, `finished_TM_FIO  in  1`
- `FileIO_Wen_ICache  out  1`, `FileIO_Addr_ICache  out  10`, `FileIO_Din_ICache  out  32`, `FileIO_Dout_ICache  in  32  (unused)`
- `FIO_MEMWRITE  out  1`, `FIO_ADDR  out  addr_width`, `FIO_WRITE_DATA  out  256`, `FIO_READ_DATA  in  256`
- `FIO_CACHE_LAT_WRITE  out  1`, `FIO_CACHE_LAT_VALUE  out  5`, `FIO_CACHE_MEM_ADDR  out  mem_addr_width`

## Operation

**Header word**
- Fields: op[31:28], base[25:16], cnt[9:0].
- N = cnt+1, range 1..1024.
- Address k = base+k, truncated to the target port width (wraps).

**Opcodes**
- 0 TM: N data words; each issues one TM write of word[28:0]. base is ignored.
- 1 IC: N words; each writes ICache[base+k].
- 2 MEM: 8·N words.
  - Each group of 8 forms one line: first word is bits[255:224], last word is bits[31:0].
  - Each completed line writes MEM[base+k].
- 3 EMU: N words; each writes latency word[4:0] at base+k.
- 4 RUN:
  - Drive start_FIO_TM high; a 32-bit cycle counter counts from 0 while waiting.
  - When finished_TM_FIO is sampled high: drop start and emit one out word = counter value.
- 5 DUMP: for each of N lines starting at base:
  - set FIO_ADDR;
  - wait MEM_RD_LAT cycles;
  - capture the line;
  - emit 8 words, MSB word first.
- 6 CLEAR: one-cycle clear_FIO_TM pulse. No data words.
- 7–15: set cmd_err, drop the header, return to IDLE.

**State machine**
- States: IDLE, TM_WR, IC_WR, MEM_COL, MEM_WR, EMU_WR, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT.
- Each state exits to IDLE when its count is exhausted.

**Write strobes**
- Write enables are registered single-cycle pulses.
- Data and address are valid in the same cycle as the pulse.

## Timing
- Reset: all outputs 0, in_ready 0, FSM = IDLE, partial MEM line discarded, counters cleared, cmd_err cleared. Reset mid-operation aborts with no further strobes.
- in_ready:
  - 1 in IDLE, TM_WR, IC_WR, EMU_WR and MEM_COL;
  - 0 in MEM_WR, RUN and the DUMP states.
- Handshake: a word transfers when in_valid && in_ready.
- Write latency:
  - TM/IC/EMU: the strobe is asserted on the cycle after the word is accepted.
  - MEM: FIO_MEMWRITE is asserted one cycle after the 8th word (MEM_WR state).
  - MEM_COL is re-entered the following cycle, giving 9 cycles/line at full rate.
- Header to first data word: no bubble; the first data word can be accepted the cycle after the header.
- RUN:
  - start rises the cycle after the RUN header.
  - The counter increments every cycle start is high.
  - finished sampled high at edge t → start low and out_valid high from t+1.
  - out_valid is held until out_ready; then return to IDLE.
- DUMP:
  - FIO_ADDR is updated on DUMP_RD entry; capture happens after exactly MEM_RD_LAT cycles.
  - out_valid is held while out_ready is low, and out_data is stable while stalled.
  - The next line's address is issued only after word 8 transfers.
- Outputs hold their last values between strobes.
- No overlap: a new header is accepted only in IDLE.

## Test plan
- **Reset:** assert rst mid MEM_COL after 3 words → no FIO_MEMWRITE, all outputs 0; after release, in_ready=1.
- **IC load:** header 0x1000_0003 (base 0, N=4), data 0xA0..0xA3 → four FileIO_Wen_ICache pulses at addrs 0..3 with matching Din, each one cycle after acceptance.
- **MEM load:** header 0x2005_0000, words 0x11111111..0x88888888 → one FIO_MEMWRITE at FIO_ADDR=5 with FIO_WRITE_DATA = 0x11111111_22222222…88888888.
- **RUN:** header 0x4000_0000; finished asserted 20 cycles after start rises → start falls, out_data = 20, with out_ready held low 3 cycles to check stability.
- **DUMP with backpressure:** MEM model returning line = addr pattern, header 0x5001_0001 → 16 words for lines 1 and 2, MSB first, correct under random out_ready.
- **Errors and wrap:** op 0xF header → cmd_err=1, FSM back in IDLE. EMU header base 0xFF, N=2 → FIO_CACHE_MEM_ADDR 0xFF then 0x00.
